// File: rtl/run_detect_pkg.sv
// Shared types and helpers for the run detector.
//   state_t   : control FSM encoding (IDLE, COUNT, INRUN)
//   run_cnt_w : width of a counter that must hold 0..run_len
package run_detect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        INRUN = 2'd2
    } state_t;

    function automatic int unsigned run_cnt_w(input int unsigned run_len);
        return 32'($clog2(run_len + 32'd1));
    endfunction

endpackage

// File: rtl/run_detect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : increment request; ignored once cnt reaches MAX
//   cnt      : registered count value
module sat_counter #(
    parameter int unsigned W   = 8,
    parameter int unsigned MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/run_detect_ctrl.sv
// Run detector: captures a threshold from the sample stream on command, then
// counts runs of RUN_LEN or more consecutive valid samples strictly beyond it.
// Optional feature macro: RUN_DETECT_MAX_RUN_EN adds max_run (longest run seen).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   strt_cap_cmp  : capture sig as threshold, clear counters, start comparing
//   stop          : return to IDLE, hold thr and n_runs
//   sig, sig_vld  : sample and its valid qualifier
//   thr           : captured threshold
//   n_runs        : saturating count of qualifying runs since capture
//   run_det       : one-cycle pulse when a run reaches RUN_LEN
//   in_run        : current run length is at least RUN_LEN
//   busy          : FSM not in IDLE
//   max_run       : (macro only) longest run since capture, in samples
module run_detect_ctrl
    import run_detect_pkg::*;
#(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned ABOVE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strt_cap_cmp,
    input  logic              stop,
    input  logic [DATA_W-1:0] sig,
    input  logic              sig_vld,
    output logic [DATA_W-1:0] thr,
    output logic [CNT_W-1:0]  n_runs,
    output logic              run_det,
    output logic              in_run,
    output logic              busy
`ifdef RUN_DETECT_MAX_RUN_EN
    ,
    output logic [15:0]       max_run
`endif
);

    localparam int unsigned RCW      = run_cnt_w(RUN_LEN);
    localparam int unsigned NRUN_MAX = (2 ** CNT_W) - 1;

    state_t           state;
    state_t           state_nxt;
    logic [RCW-1:0]   run_cnt;
    logic             qual;
    logic             thr_ld;
    logic             run_clr;
    logic             run_inc;
    logic             nrun_clr;
    logic             nrun_inc;
    logic             det_nxt;

    // Strict compare; equality never qualifies.
    assign qual = (ABOVE != 0) ? (sig > thr) : (sig < thr);

    // State, threshold and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            thr     <= '0;
            run_det <= 1'b0;
            in_run  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            if (thr_ld) begin
                thr <= sig;
            end
            run_det <= det_nxt;
            in_run  <= (state_nxt == INRUN);
            busy    <= (state_nxt != IDLE);
        end
    end

    // Next state and counter controls; capture beats stop.
    always_comb begin
        state_nxt = state;
        thr_ld    = 1'b0;
        run_clr   = 1'b0;
        run_inc   = 1'b0;
        nrun_clr  = 1'b0;
        nrun_inc  = 1'b0;
        det_nxt   = 1'b0;
        if (strt_cap_cmp) begin
            thr_ld    = 1'b1;
            run_clr   = 1'b1;
            nrun_clr  = 1'b1;
            state_nxt = COUNT;
        end else if (stop) begin
            run_clr   = 1'b1;
            state_nxt = IDLE;
        end else if (sig_vld) begin
            case (state)
                COUNT: begin
                    if (qual) begin
                        run_inc = 1'b1;
                        // This sample completes the run.
                        if (run_cnt == RCW'(RUN_LEN - 1)) begin
                            nrun_inc  = 1'b1;
                            det_nxt   = 1'b1;
                            state_nxt = INRUN;
                        end
                    end else begin
                        run_clr = 1'b1;
                    end
                end
                INRUN: begin
                    if (!qual) begin
                        run_clr   = 1'b1;
                        state_nxt = COUNT;
                    end
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.W(RCW), .MAX(RUN_LEN)) u_run_cnt (
        .clk (clk),
        .rst (rst),
        .clr (run_clr),
        .inc (run_inc),
        .cnt (run_cnt)
    );

    sat_counter #(.W(CNT_W), .MAX(NRUN_MAX)) u_n_runs (
        .clk (clk),
        .rst (rst),
        .clr (nrun_clr),
        .inc (nrun_inc),
        .cnt (n_runs)
    );

`ifdef RUN_DETECT_MAX_RUN_EN
    logic [15:0] len_cnt;
    logic        len_inc;
    logic [15:0] len_nxt;

    // Full run length keeps counting past RUN_LEN, up to 0xFFFF.
    assign len_inc = (state != IDLE) && !strt_cap_cmp && !stop && sig_vld && qual;
    assign len_nxt = len_cnt + 16'd1;

    sat_counter #(.W(16), .MAX(16'hFFFF)) u_len_cnt (
        .clk (clk),
        .rst (rst),
        .clr (run_clr),
        .inc (len_inc),
        .cnt (len_cnt)
    );

    // Track the value the length counter takes this edge.
    always_ff @(posedge clk) begin
        if (rst || strt_cap_cmp) begin
            max_run <= '0;
        end else if (len_inc && (len_cnt != 16'hFFFF) && (len_nxt > max_run)) begin
            max_run <= len_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Self-checking bench for run_detect_ctrl: directed scenarios followed by
// randomized traffic, all checked each cycle against a behavioural model.
module tb_run_detect_ctrl;

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned RUN_LEN = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned ABOVE   = 1;
    localparam int          NMAX    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              strt_cap_cmp = 1'b0;
    logic              stop = 1'b0;
    logic [DATA_W-1:0] sig = '0;
    logic              sig_vld = 1'b0;
    logic [DATA_W-1:0] thr;
    logic [CNT_W-1:0]  n_runs;
    logic              run_det;
    logic              in_run;
    logic              busy;
`ifdef RUN_DETECT_MAX_RUN_EN
    logic [15:0]       max_run;
`endif

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state: run length is an unbounded integer.
    int thr_m = 0;
    int n_m   = 0;
    int len_m = 0;
    int max_m = 0;
    bit act_m = 1'b0;
    bit det_m = 1'b0;

    always #5 clk = ~clk;

    run_detect_ctrl #(
        .DATA_W (DATA_W),
        .RUN_LEN(RUN_LEN),
        .CNT_W  (CNT_W),
        .ABOVE  (ABOVE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .strt_cap_cmp(strt_cap_cmp),
        .stop        (stop),
        .sig         (sig),
        .sig_vld     (sig_vld),
        .thr         (thr),
        .n_runs      (n_runs),
        .run_det     (run_det),
        .in_run      (in_run),
        .busy        (busy)
`ifdef RUN_DETECT_MAX_RUN_EN
        ,
        .max_run     (max_run)
`endif
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit qualifies(input int sv, input int tv);
        return (ABOVE != 0) ? (sv > tv) : (sv < tv);
    endfunction

    // Apply one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input bit r, input bit s, input bit p, input int sv, input bit v);
        rst          = r;
        strt_cap_cmp = s;
        stop         = p;
        sig          = DATA_W'(sv);
        sig_vld      = v;
        @(posedge clk);
        det_m = 1'b0;
        if (r) begin
            thr_m = 0; n_m = 0; len_m = 0; max_m = 0; act_m = 1'b0;
        end else if (s) begin
            thr_m = sv; n_m = 0; len_m = 0; max_m = 0; act_m = 1'b1;
        end else if (p) begin
            act_m = 1'b0; len_m = 0;
        end else if (act_m && v) begin
            if (qualifies(sv, thr_m)) begin
                len_m++;
                if (len_m == RUN_LEN) begin
                    det_m = 1'b1;
                    if (n_m < NMAX) n_m++;
                end
                if (len_m > max_m && len_m <= 65535) max_m = len_m;
            end else begin
                len_m = 0;
            end
        end
        #1;
        check_eq("thr",     int'(thr),     thr_m);
        check_eq("n_runs",  int'(n_runs),  n_m);
        check_eq("run_det", int'(run_det), int'(det_m));
        check_eq("in_run",  int'(in_run),  int'(act_m && len_m >= RUN_LEN));
        check_eq("busy",    int'(busy),    int'(act_m));
`ifdef RUN_DETECT_MAX_RUN_EN
        check_eq("max_run", int'(max_run), max_m);
`endif
    endtask

    task automatic samples(input int a, input int b, input int c, input int d);
        step(0, 0, 0, a, 1);
        step(0, 0, 0, b, 1);
        step(0, 0, 0, c, 1);
        step(0, 0, 0, d, 1);
    endtask

    initial begin
        // Reset: also checks that all outputs come up zero.
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 77, 1);
        check_eq("rst_thr", int'(thr), 0);
        check_eq("rst_busy", int'(busy), 0);

        // Capture at 100; capturing sample itself is not compared.
        step(0, 1, 0, 100, 1);
        check_eq("cap_thr", int'(thr), 100);
        check_eq("cap_busy", int'(busy), 1);

        // Basic run.
        samples(101, 150, 200, 101);
        check_eq("basic_det", int'(run_det), 1);
        check_eq("basic_n", int'(n_runs), 1);
        step(0, 0, 0, 300, 1);
        check_eq("basic_one_pulse", int'(run_det), 0);
        step(0, 0, 0, 400, 1);
        step(0, 0, 0, 100, 1);
        check_eq("basic_eq_ends", int'(in_run), 0);

        // Broken runs, equality breaks.
        step(0, 1, 0, 100, 1);
        samples(101, 102, 103, 100);
        step(0, 0, 0, 101, 1);
        step(0, 0, 0, 102, 1);
        step(0, 0, 0, 103, 1);
        check_eq("broken_n", int'(n_runs), 0);

        // Invalid cycles do not break a run.
        step(0, 1, 0, 100, 1);
        step(0, 0, 0, 101, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 102, 1);
        step(0, 0, 0, 103, 1);
        step(0, 0, 0, 104, 1);
        check_eq("gap_det", int'(run_det), 1);
        check_eq("gap_n", int'(n_runs), 1);

        // Saturation of the 2-bit run counter.
        step(0, 1, 0, 100, 1);
        for (int i = 0; i < 5; i++) begin
            samples(110, 120, 130, 140);
            check_eq("sat_det", int'(run_det), 1);
            step(0, 0, 0, 100, 1);
        end
        check_eq("sat_n", int'(n_runs), NMAX);

        // Capture and stop together mid-run: capture wins.
        step(0, 0, 0, 200, 1);
        step(0, 0, 0, 200, 1);
        step(0, 1, 1, 50, 1);
        check_eq("prec_thr", int'(thr), 50);
        check_eq("prec_n", int'(n_runs), 0);
        check_eq("prec_busy", int'(busy), 1);

        // Stop alone: hold n_runs, ignore samples.
        samples(51, 52, 53, 54);
        step(0, 0, 1, 60, 1);
        check_eq("stop_busy", int'(busy), 0);
        samples(70, 80, 90, 99);
        check_eq("stop_n", int'(n_runs), 1);
        check_eq("stop_thr", int'(thr), 50);

        // Randomized traffic near the threshold.
        for (int i = 0; i < 4000; i++) begin
            bit r, s, p, v;
            int sv;
            r = ($urandom_range(0, 599) == 0);
            s = ($urandom_range(0, 69) == 0);
            p = ($urandom_range(0, 89) == 0);
            v = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) begin
                sv = int'($urandom_range(0, 4095));
            end else begin
                sv = thr_m + int'($urandom_range(0, 8)) - 3;
                if (sv < 0) sv = 0;
                if (sv > 4095) sv = 4095;
            end
            step(r, s, p, sv, v);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/run_detect_ctrl.md
Name: run_detect_ctrl

Overview:
- Parametrised run detector: captures a threshold from the sample stream on command, then counts qualifying runs.
- A qualifying run is RUN_LEN or more consecutive valid samples strictly beyond the threshold.
- Control FSM and datapath are integrated in one block: threshold register, run counter and saturating run-event counter.
- Sits behind the sample source; its count and pulse outputs feed the status/readout logic.

Parameters:
DATA_W, 12, sample and threshold width (unsigned)
RUN_LEN, 4, consecutive qualifying samples that constitute a run (legal range 1..255)
CNT_W, 8, width of the run-event counter n_runs
ABOVE, 1, 1: qualify when sig > thr; 0: qualify when sig < thr

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
strt_cap_cmp  in  1  capture current sig as threshold, clear counters, begin comparing
stop  in  1  return to IDLE; freeze n_runs
sig  in  DATA_W  sample
sig_vld  in  1  sig is a valid sample this cycle
thr  out  DATA_W  captured threshold
n_runs  out  CNT_W  number of qualifying runs since capture (saturating)
run_det  out  1  one-cycle pulse, the cycle after a run reaches RUN_LEN
in_run  out  1  high while the current run length is >= RUN_LEN
busy  out  1  FSM not in IDLE

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, port rst.
- Reset values: state IDLE; thr, n_runs, run_cnt = 0; run_det, in_run, busy = 0. Reset overrides all inputs in the same cycle.
- Qualify: q = ABOVE ? (sig > thr) : (sig < thr). Unsigned compare. Equality never qualifies.
- run_cnt width = $clog2(RUN_LEN+1). run_cnt saturates at RUN_LEN and never wraps.
- States:
  - IDLE (busy=0). Samples are ignored.
  - COUNT: comparing, run_cnt < RUN_LEN.
  - INRUN: run_cnt == RUN_LEN, in_run=1.
- strt_cap_cmp (any state, including IDLE, COUNT, INRUN):
  - Next cycle: thr <= sig, n_runs <= 0, run_cnt <= 0, state COUNT.
  - The capturing sample is never compared, even when sig_vld=1.
- Precedence when strt_cap_cmp and stop are both high: strt_cap_cmp wins.
- stop (without strt_cap_cmp): next state IDLE, run_cnt <= 0. thr and n_runs hold their values.
- COUNT, sig_vld & q:
  - run_cnt+1. If the result equals RUN_LEN: state INRUN, n_runs+1 (saturate at 2^CNT_W-1), run_det=1 for one cycle.
- COUNT, sig_vld & !q: run_cnt <= 0.
- INRUN, sig_vld & q: hold. No further increment; one count per run regardless of run length.
- INRUN, sig_vld & !q: run_cnt <= 0, state COUNT.
- sig_vld=0: all state and counters hold. Invalid cycles do not break a run.
- RUN_LEN=1: the first qualifying sample goes straight COUNT->INRUN.
- Latency: sample at cycle t -> run_cnt, n_runs and in_run updated, run_det pulsed, at t+1.
- All outputs are registered.

Optional Feature:
- Macro: RUN_DETECT_MAX_RUN_EN.
- Defined: adds output max_run [15:0], the longest run observed since capture, counted in valid qualifying samples.
  - A separate 16-bit run-length counter saturates at 0xFFFF and keeps counting past RUN_LEN.
  - max_run updates the cycle after a sample raises the counter above max_run.
  - Cleared by capture and by rst; held in IDLE.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package run_detect_pkg: state_t enum {IDLE, COUNT, INRUN} (2-bit encoding) and a function run_cnt_w(RUN_LEN) returning $clog2(RUN_LEN+1).
- Sub-module sat_counter (parameters W, MAX), used for run_cnt, n_runs and the optional max_run counter.
- FSM and compare logic stay in run_detect_ctrl.

Test Plan:
- Reset/capture: rst, then strt_cap_cmp with sig=100 -> thr=100, n_runs=0, busy=1; that sample is not counted.
- Basic run, ABOVE=1, RUN_LEN=4, thr=100:
  - Valid samples 101,150,200,101 -> run_det one pulse after the 4th, n_runs=1, in_run=1.
  - Then 300,400 -> no new pulse.
  - Then 100 -> in_run=0, state COUNT.
- Broken runs: 101,102,103,100,101,102,103 -> n_runs=0. Equality resets; no false detect.
- Gapped validity: 101,(vld=0 x3),102,103,104 -> run_det=1, n_runs=1.
- Saturation, CNT_W=2: five separate 4-sample runs -> n_runs sticks at 3, run_det still pulses each run.
- Command precedence: strt_cap_cmp and stop together mid-run with sig=50 -> thr=50, n_runs=0, state COUNT.
- stop alone -> IDLE, n_runs held; subsequent qualifying samples are ignored.
